// File: rtl/vga_sram_pkg.sv
// Shared definitions for the VGA display and capture paths around the async SRAM.
// Frame geometry, FSM state encodings and the {Y,X} SRAM address packing.
package vga_sram_pkg;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT_SOF,
    C_CAPTURE,
    C_DRAIN
  } cap_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_REQ,
    W_SETUP,
    W_STROBE,
    W_HOLD
  } wr_state_t;

  function automatic logic [19:0] pack_addr(input logic [9:0] y, input logic [9:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/sram_frame_writer_fifo.sv
// Synchronous FIFO with full/empty flags; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sram_frame_writer.sv
// Captures one framed 8-bit pixel stream into the async SRAM at {Y,X}, using
// 3-cycle write cycles on the shared bus only while the arbiter grants it.
module sram_frame_writer
  import vga_sram_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sof,
  input  logic        sol,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int         BW        = $clog2(BURST_MAX + 1);
  localparam logic [9:0] H_LIM     = 10'(H_ACT);
  localparam logic [9:0] V_LIM     = 10'(V_ACT);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

  cap_state_t     cap_q, cap_d;
  wr_state_t      wr_q, wr_d;
  logic [9:0]     x_q, x_d, y_q, y_d;
  logic [9:0]     x_eff, y_eff;
  logic           overflow_q, overflow_d;
  logic           done_q, done_d;
  logic [19:0]    addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic           holdoff_q, holdoff_d;
  logic           push, pop, full, empty;
  logic [27:0]    fifo_din, fifo_dout;

  sync_fifo #(
    .WIDTH (28),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q      <= C_IDLE;
      wr_q       <= W_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      burst_q    <= '0;
      holdoff_q  <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      wr_q       <= wr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      burst_q    <= burst_d;
      holdoff_q  <= holdoff_d;
    end
  end

  // sol is applied before a same-cycle pixel, so that pixel lands at X=0 of the new line.
  always_comb begin
    x_eff      = sol ? 10'd0 : x_q;
    y_eff      = (sol && (y_q < V_LIM)) ? y_q + 10'd1 : y_q;
    cap_d      = cap_q;
    x_d        = x_q;
    y_d        = y_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    push       = 1'b0;
    fifo_din   = {pack_addr(y_eff, x_eff), pix_data};
    unique case (cap_q)
      C_IDLE: begin
        if (start) begin
          cap_d      = C_WAIT_SOF;
          overflow_d = 1'b0;
        end
      end
      C_WAIT_SOF: begin
        if (abort) begin
          cap_d = C_IDLE;
        end else if (sof) begin
          cap_d = C_CAPTURE;
          x_d   = '0;
          y_d   = '0;
        end
      end
      C_CAPTURE: begin
        if (sof || abort) begin
          cap_d = C_DRAIN;
        end else begin
          x_d = x_eff;
          y_d = y_eff;
          if (pix_valid) begin
            if (x_eff < H_LIM) x_d = x_eff + 10'd1;
            if ((x_eff < H_LIM) && (y_eff < V_LIM)) begin
              if (full && !pop) overflow_d = 1'b1;
              else push = 1'b1;
            end
          end
        end
      end
      C_DRAIN: begin
        if (empty && (wr_q == W_IDLE)) begin
          cap_d  = C_IDLE;
          done_d = 1'b1;
        end
      end
      default: cap_d = C_IDLE;
    endcase
  end

  // A burst that hit BURST_MAX leaves holdoff set so W_IDLE skips one request cycle.
  always_comb begin
    wr_d      = wr_q;
    pop       = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    burst_d   = burst_q;
    holdoff_d = holdoff_q;
    unique case (wr_q)
      W_IDLE: begin
        if (holdoff_q) holdoff_d = 1'b0;
        else if (!empty) wr_d = W_REQ;
      end
      W_REQ: begin
        if (bus_gnt) begin
          pop     = 1'b1;
          burst_d = BW'(1);
          wr_d    = W_SETUP;
        end
      end
      W_SETUP:  wr_d = W_STROBE;
      W_STROBE: wr_d = W_HOLD;
      W_HOLD: begin
        if (!empty && (burst_q < BURST_LIM)) begin
          pop     = 1'b1;
          burst_d = burst_q + BW'(1);
          wr_d    = W_SETUP;
        end else begin
          wr_d      = W_IDLE;
          holdoff_d = (burst_q == BURST_LIM);
        end
      end
      default: wr_d = W_IDLE;
    endcase
    if (pop) begin
      addr_d = fifo_dout[27:8];
      data_d = fifo_dout[7:0];
    end
  end

  always_comb begin
    bus_req    = 1'b0;
    sram_ce_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    unique case (wr_q)
      W_REQ: bus_req = 1'b1;
      W_SETUP, W_HOLD: begin
        bus_req    = 1'b1;
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      W_STROBE: begin
        bus_req    = 1'b1;
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_addr   = addr_q;
  assign sram_dq_out = {8'h00, data_q};
  assign sram_oe_n   = 1'b1;
  assign sram_ub_n   = 1'b1;
  assign sram_lb_n   = 1'b0;
  assign busy        = (cap_q != C_IDLE);
  assign done        = done_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed bench for sram_frame_writer: a negedge monitor records every SRAM
// write strobe, and each scenario task checks those records against hand values.
module tb_sram_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, sof = 1'b0, sol = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        bus_gnt = 1'b0;
  logic        bus_req;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
  logic        busy, done, overflow;

  int compared = 0;
  int mismatched = 0;
  int cyc_cnt = 0;

  logic [19:0] wr_addr_q[$];
  logic [15:0] wr_dq_q[$];
  int          wr_cyc_q[$];
  int          strobe_bad = 0;
  int          ce_low_cnt = 0;
  bit          prev_we_low = 1'b0;

  sram_frame_writer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sof(sof), .sol(sol),
    .pix_valid(pix_valid), .pix_data(pix_data), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (rst && !sram_we_n) begin
      wr_addr_q.push_back(sram_addr);
      wr_dq_q.push_back(sram_dq_out);
      wr_cyc_q.push_back(cyc_cnt);
      if (sram_ce_n || !sram_dq_oe || prev_we_low) strobe_bad++;
    end
    prev_we_low = rst && !sram_we_n;
    if (rst && !sram_ce_n) ce_low_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_dq_q.delete();
    wr_cyc_q.delete();
    strobe_bad = 0;
    ce_low_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_sof();
    sof = 1'b1; step(); sof = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wr_addr_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(input int budget, output int pulses, output bit idle);
    pulses = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) pulses++;
      if (!busy) break;
    end
    idle = !busy;
    repeat (2) begin
      step();
      if (done) pulses++;
    end
  endtask

  task automatic test_reset();
    compared++;
    if ({bus_req, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe, busy, done, overflow} !== 10'b0111100000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b want 0111100000",
               {bus_req, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe, busy, done, overflow});
    end
    compared++;
    if ({sram_addr, sram_dq_out} !== 36'h0) begin
      mismatched++;
      $display("FAIL reset_bus: got addr %h dq %h want 0/0", sram_addr, sram_dq_out);
    end
  endtask

  task automatic test_basic();
    bit ok, idle;
    int pulses, p0;
    clear_mon();
    bus_gnt = 1'b1;
    pulse_start();
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy: got %b want 1", busy); end
    pulse_sof();
    p0 = 0;
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      pix_data = 8'h11 + 8'(i);
      step();
      if (i == 0) p0 = cyc_cnt;
    end
    pix_valid = 1'b0;
    wait_writes(4, 60, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL basic_wait: got %0d writes want 4", wr_addr_q.size()); end
    pulse_sof();
    wait_done(40, pulses, idle);
    compared++;
    if (wr_addr_q.size() !== 4) begin mismatched++; $display("FAIL basic_count: got %0d want 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      compared++;
      if (wr_addr_q[i] !== 20'(i) || wr_dq_q[i] !== 16'h0011 + 16'(i)) begin
        mismatched++;
        $display("FAIL basic_write%0d: got addr %h dq %h want %h/%h", i, wr_addr_q[i], wr_dq_q[i], 20'(i), 16'h0011 + 16'(i));
      end
    end
    compared++;
    if (wr_cyc_q.size() == 0 || wr_cyc_q[0] !== p0 + 3) begin
      mismatched++;
      $display("FAIL basic_latency: got WE cycle %0d want %0d", wr_cyc_q.size() ? wr_cyc_q[0] : -1, p0 + 3);
    end
    compared++;
    if (ce_low_cnt !== 12 || strobe_bad !== 0) begin
      mismatched++;
      $display("FAIL basic_timing: got ce_low %0d strobe_bad %0d want 12/0", ce_low_cnt, strobe_bad);
    end
    compared++;
    if (!idle || pulses !== 1) begin mismatched++; $display("FAIL basic_done: got idle %b pulses %0d want 1/1", idle, pulses); end
  endtask

  task automatic test_sol_same_cycle();
    bit ok, idle;
    int pulses;
    clear_mon();
    bus_gnt = 1'b1;
    pulse_start();
    pulse_sof();
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1; pix_data = 8'h20 + 8'(i); step();
    end
    sol = 1'b1; pix_data = 8'hA5; step();
    sol = 1'b0; pix_data = 8'hA6; step();
    sof = 1'b1; sol = 1'b1; pix_data = 8'hEE; step();
    sof = 1'b0; sol = 1'b0; pix_valid = 1'b0;
    wait_done(100, pulses, idle);
    compared++;
    if (wr_addr_q.size() !== 7) begin mismatched++; $display("FAIL sol_count: got %0d want 7", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 7) begin
      compared++;
      if (wr_addr_q[4] !== 20'h00004 || wr_dq_q[4] !== 16'h0024) begin
        mismatched++; $display("FAIL sol_last_line0: got %h/%h want 00004/0024", wr_addr_q[4], wr_dq_q[4]);
      end
      compared++;
      if (wr_addr_q[5] !== 20'h00400 || wr_dq_q[5] !== 16'h00A5) begin
        mismatched++; $display("FAIL sol_same_cycle: got %h/%h want 00400/00a5", wr_addr_q[5], wr_dq_q[5]);
      end
      compared++;
      if (wr_addr_q[6] !== 20'h00401 || wr_dq_q[6] !== 16'h00A6) begin
        mismatched++; $display("FAIL sol_next: got %h/%h want 00401/00a6", wr_addr_q[6], wr_dq_q[6]);
      end
    end
    compared++;
    if (!idle || pulses !== 1) begin mismatched++; $display("FAIL sol_done: got idle %b pulses %0d want 1/1", idle, pulses); end
  endtask

  task automatic test_overflow();
    bit ok, idle;
    int pulses, bad;
    clear_mon();
    bus_gnt = 1'b0;
    pulse_start();
    pulse_sof();
    for (int i = 0; i < 20; i++) begin
      pix_valid = 1'b1; pix_data = 8'(i); step();
    end
    pix_valid = 1'b0;
    repeat (3) step();
    compared++;
    if (overflow !== 1'b1 || bus_req !== 1'b1 || wr_addr_q.size() !== 0) begin
      mismatched++;
      $display("FAIL ovf_stall: got ovf %b req %b writes %0d want 1/1/0", overflow, bus_req, wr_addr_q.size());
    end
    bus_gnt = 1'b1;
    wait_writes(16, 200, ok);
    pulse_abort();
    wait_done(100, pulses, idle);
    compared++;
    if (wr_addr_q.size() !== 16) begin mismatched++; $display("FAIL ovf_count: got %0d want 16", wr_addr_q.size()); end
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== 20'(i) || wr_dq_q[i] !== 16'(i)) bad++;
    compared++;
    if (bad !== 0 || wr_addr_q.size() == 0 || wr_addr_q[0] !== 20'h0) begin
      mismatched++; $display("FAIL ovf_order: got %0d bad entries want 0", bad);
    end
    compared++;
    if (overflow !== 1'b1 || pulses !== 1) begin
      mismatched++; $display("FAIL ovf_sticky: got ovf %b pulses %0d want 1/1", overflow, pulses);
    end
  endtask

  task automatic test_burst();
    bit ok, idle, fell, rose;
    int pulses, at_fall, low;
    clear_mon();
    bus_gnt = 1'b0;
    pulse_start();
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL start_clears_ovf: got %b want 0", overflow); end
    pulse_sof();
    for (int i = 0; i < 12; i++) begin
      pix_valid = 1'b1; pix_data = 8'h30 + 8'(i); step();
    end
    pix_valid = 1'b0;
    bus_gnt = 1'b1;
    fell = 1'b0; rose = 1'b0; at_fall = -1; low = 0;
    for (int i = 0; i < 200 && !rose; i++) begin
      step();
      if (!fell && !bus_req && wr_addr_q.size() > 0) begin
        fell = 1'b1; at_fall = wr_addr_q.size(); low = 1;
      end else if (fell) begin
        if (bus_req) rose = 1'b1;
        else low++;
      end
    end
    wait_writes(12, 100, ok);
    pulse_abort();
    wait_done(100, pulses, idle);
    compared++;
    if (at_fall !== 8) begin mismatched++; $display("FAIL burst_release: got %0d writes at release want 8", at_fall); end
    compared++;
    if (!rose || low < 1) begin mismatched++; $display("FAIL burst_gap: got rose %b low %0d want 1/>=1", rose, low); end
    compared++;
    if (wr_addr_q.size() !== 12) begin mismatched++; $display("FAIL burst_count: got %0d want 12", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 12) begin
      compared++;
      if (wr_addr_q[8] !== 20'h8 || wr_dq_q[11] !== 16'h003B) begin
        mismatched++; $display("FAIL burst_tail: got %h/%h want 00008/003b", wr_addr_q[8], wr_dq_q[11]);
      end
    end
  endtask

  task automatic test_line_clip();
    bit ok, idle;
    int pulses, bad;
    clear_mon();
    bus_gnt = 1'b1;
    pulse_start();
    pulse_sof();
    for (int i = 0; i < 700; i++) begin
      pix_valid = 1'b1; pix_data = 8'(i); step();
      pix_valid = 1'b0; repeat (3) step();
    end
    wait_writes(640, 3000, ok);
    repeat (20) step();
    pulse_abort();
    wait_done(100, pulses, idle);
    compared++;
    if (wr_addr_q.size() !== 640) begin mismatched++; $display("FAIL clip_count: got %0d want 640", wr_addr_q.size()); end
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== 20'(i) || wr_dq_q[i] !== {8'h00, 8'(i)}) bad++;
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL clip_data: got %0d bad entries want 0", bad); end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL clip_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_reset_strobe();
    bit found;
    clear_mon();
    bus_gnt = 1'b1;
    pulse_start();
    pulse_sof();
    pix_valid = 1'b1; pix_data = 8'h77; step(); pix_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!sram_we_n) found = 1'b1;
    end
    compared++;
    if (!found) begin mismatched++; $display("FAIL rst_strobe_find: got no strobe want one"); end
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({sram_we_n, sram_ce_n, sram_dq_oe, busy, bus_req} !== 5'b11000) begin
      mismatched++;
      $display("FAIL rst_async: got %b want 11000", {sram_we_n, sram_ce_n, sram_dq_oe, busy, bus_req});
    end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_abort_wait_sof();
    clear_mon();
    pulse_start();
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL abort_armed: got %b want 1", busy); end
    pulse_abort();
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("FAIL abort_idle: got busy %b done %b want 0/0", busy, done); end
    step();
    compared++;
    if (done !== 1'b0 || wr_addr_q.size() !== 0) begin
      mismatched++; $display("FAIL abort_nodone: got done %b writes %0d want 0/0", done, wr_addr_q.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    #5;
    test_reset();
    step(); step();
    rst = 1'b1;
    step();
    test_basic();
    test_sol_same_cycle();
    test_overflow();
    test_burst();
    test_line_clip();
    test_reset_strobe();
    test_abort_wait_sof();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_frame_writer.md
Name: sram_frame_writer

Overview:
Capture-side counterpart to the VGA display path. The display path reads 8-bit pixels from the async SRAM at address {Y,X}; this block writes them. It accepts a framed pixel stream (sof/sol/pix_valid), buffers {addr,data} in a small FIFO, and performs 3-cycle SRAM write cycles on the shared bus. It only drives the bus while the SRAM arbiter grants it.

Parameters:
H_ACT, 640, active pixels per line; pixels with X>=H_ACT are dropped
V_ACT, 480, active lines; pixels with Y>=V_ACT are dropped
FIFO_DEPTH, 16, entries of {addr[19:0],data[7:0]}; power of two
BURST_MAX, 8, max writes per grant before the bus is released

Ports:
clk  in  1  50 MHz system clock
rst  in  1  async reset, active-low
start  in  1  one-cycle pulse; arms capture of one frame
abort  in  1  one-cycle pulse; ends capture and drains the FIFO
sof  in  1  start-of-frame pulse; also starts line 0
sol  in  1  start-of-line pulse for lines 1..n
pix_valid  in  1  pixel strobe
pix_data  in  8  grey pixel
bus_req  out  1  SRAM bus request
bus_gnt  in  1  SRAM bus grant; arbiter holds it while bus_req=1
sram_addr  out  20  {Y[9:0],X[9:0]}
sram_dq_out  out  16  {8'h00,data}
sram_dq_oe  out  1  1 = drive DQ
sram_ce_n  out  1  chip enable
sram_we_n  out  1  write enable
sram_oe_n  out  1  output enable; held 1
sram_ub_n  out  1  held 1
sram_lb_n  out  1  held 0
busy  out  1  capture FSM not in C_IDLE
done  out  1  one-cycle pulse when the frame is fully written
overflow  out  1  sticky; a pixel was dropped because the FIFO was full

Behaviour:
- Reset (async, rst=0) sets everything to defaults: both FSMs idle, FIFO empty, X=Y=0, bus_req=0, sram_ce_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, busy=0, done=0, overflow=0. A reset during a write cycle aborts it immediately.
- Capture FSM:
  - C_IDLE --start--> C_WAIT_SOF. start clears overflow.
  - C_WAIT_SOF --sof--> C_CAPTURE with X=0, Y=0.
  - C_CAPTURE --(sof or abort)--> C_DRAIN.
  - C_DRAIN --(FIFO empty and write FSM in W_IDLE)--> C_IDLE, with a done pulse.
  - abort in C_WAIT_SOF goes directly to C_IDLE with no done pulse.
- Coordinates in C_CAPTURE:
  - sol sets X=0 and Y=Y+1, saturating at V_ACT.
  - An accepted pixel writes {Y,X,pix_data} into the FIFO, then X=X+1, saturating at H_ACT.
  - Pixels with X>=H_ACT or Y>=V_ACT are discarded; they do not set overflow.
- Simultaneous events:
  - sol with pix_valid: sol applies first, so the pixel lands at X=0 of the new line.
  - sof with sol: sof wins.
  - The terminating sof does not capture a pixel presented in the same cycle.
- FIFO:
  - Push in cycle t makes the entry visible at the head in t+1.
  - Full with pix_valid: the pixel is dropped and overflow=1. X still increments.
  - Push and pop in the same cycle are allowed when the FIFO is full.
- Write FSM:
  - W_IDLE: bus_req=1 when the FIFO is non-empty → W_REQ.
  - W_REQ: wait for bus_gnt. On grant, pop the head into the address/data registers → W_SETUP.
  - W_SETUP: ce_n=0, we_n=1, dq_oe=1.
  - W_STROBE: we_n=0.
  - W_HOLD: we_n=1, ce_n=0, address and data held.
  - From W_HOLD, if the FIFO is non-empty and the burst count < BURST_MAX, pop the next entry → W_SETUP. Otherwise bus_req=0, ce_n=1, dq_oe=0 → W_IDLE.
  - After a BURST_MAX release, W_IDLE stays for at least 1 cycle before re-requesting.
- Timing:
  - Each write is 3 cycles; minimum pixel-to-WE latency is 4 cycles.
  - Address and data are stable from SETUP through HOLD.
  - bus_req is deasserted only from W_HOLD→W_IDLE.
- bus_gnt low outside W_REQ is a protocol error and is ignored.

Decomposition:
- Shared package vga_sram_pkg: H_ACT/V_ACT constants, capture and write state enums, and a pack_addr(y,x) function returning {y[9:0],x[9:0]}. The display path uses the same package.
- One sub-module, sync_fifo: parameterised width and depth, with full/empty flags and same-cycle push/pop.

Test Plan:
- Reset, start, sof, then 4 pixels 0x11..0x14 with gnt tied to 1 → writes to addr 0..3 with dq 0x0011..0x0014, 3-cycle CE low per write, WE low 1 cycle each, done after the second sof.
- sol plus pix_valid in the same cycle after 5 pixels on line 0 → that pixel written to addr {10'd1,10'd0}.
- gnt held 0 while 20 pixels are streamed → 16 entries stored, overflow=1, first write after gnt rises is addr 0.
- 12 pixels queued, gnt=1 → 8 writes, bus_req low for at least 1 cycle, then the remaining 4.
- 700 pixels on one line → only X 0..639 written, overflow stays 0.
- rst low during W_STROBE → we_n=1, ce_n=1, dq_oe=0 asynchronously; busy=0.
